// File: rtl/vc_sram_req_resp_adapter.sv
// vc_sram_req_resp_adapter
//   Val/rdy front end for the synchronous 1rw SRAM. A request that fires drives
//   the SRAM ports in the same cycle. The read data comes back one cycle later
//   (stage S1). That data is either bypassed straight to the response port or
//   captured in a 2-entry response FIFO, so response backpressure never stalls
//   the SRAM.
//
// Ports
//   clk, reset_n                  clock, async active-low reset
//   req_val/req_rdy               request handshake
//   req_type                      0 = read, 1 = write
//   req_addr/req_data/req_byte_en request fields
//   resp_val/resp_rdy             response handshake
//   resp_type/resp_data           response (data is zero for writes)
//   sram_*                        direct connection to the SRAM macro
module vc_sram_req_resp_adapter #(
  parameter  int p_mem_sz    = 32,
  parameter  int p_data_sz   = 32,
  localparam int c_addr_sz   = $clog2(p_mem_sz),
  localparam int c_num_bytes = (p_data_sz + 7) / 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic                   req_type,
  input  logic [c_addr_sz-1:0]   req_addr,
  input  logic [p_data_sz-1:0]   req_data,
  input  logic [c_num_bytes-1:0] req_byte_en,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic                   resp_type,
  output logic [p_data_sz-1:0]   resp_data,
  output logic                   sram_en,
  output logic                   sram_write_en,
  output logic [c_num_bytes-1:0] sram_byte_en,
  output logic [c_addr_sz-1:0]   sram_addr,
  output logic [p_data_sz-1:0]   sram_write_data,
  input  logic [p_data_sz-1:0]   sram_read_data
);

  typedef struct packed {
    logic                 typ;
    logic [p_data_sz-1:0] data;
  } resp_t;

  logic       fire;
  logic       s1_val, s1_type;
  resp_t      s1_resp, head, q_mem [2];
  logic       q_rd, q_wr;
  logic [1:0] q_cnt;
  logic       q_ne, enq, deq;

  // Credit check uses only registered state, so resp_rdy never reaches req_rdy.
  // s1 + queue never exceeds 2, which makes FIFO overflow impossible.
  assign req_rdy = ({1'b0, s1_val} + q_cnt) < 2'd2;
  assign fire    = req_val && req_rdy;

  assign sram_en         = fire;
  assign sram_write_en   = fire && req_type;
  assign sram_addr       = req_addr;
  assign sram_write_data = req_data;
  assign sram_byte_en    = req_byte_en;

  // The SRAM returns read-before-write data on writes; drop it.
  assign s1_resp.typ  = s1_type;
  assign s1_resp.data = s1_type ? '0 : sram_read_data;

  assign q_ne = (q_cnt != 2'd0);
  assign head = q_mem[q_rd];

  // The queue head has priority. Otherwise S1 data is bypassed in the cycle it appears.
  assign resp_val  = q_ne || s1_val;
  assign resp_type = q_ne ? head.typ  : s1_resp.typ;
  assign resp_data = q_ne ? head.data : s1_resp.data;

  // S1 data must be captured unless it leaves via the bypass this cycle.
  // Holding it in the FIFO also keeps resp_data stable during a stall, because
  // sram_read_data is valid only for that one cycle.
  assign deq = q_ne && resp_rdy;
  assign enq = s1_val && (q_ne || !resp_rdy);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_val  <= 1'b0;
      s1_type <= 1'b0;
      q_rd    <= 1'b0;
      q_wr    <= 1'b0;
      q_cnt   <= 2'd0;
    end else begin
      s1_val <= fire;
      if (fire) s1_type <= req_type;
      if (enq)  q_wr <= ~q_wr;
      if (deq)  q_rd <= ~q_rd;
      case ({enq, deq})
        2'b10:   q_cnt <= q_cnt + 2'd1;
        2'b01:   q_cnt <= q_cnt - 2'd1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // FIFO storage needs no reset; entries are qualified by q_cnt.
  always_ff @(posedge clk) begin
    if (enq) q_mem[q_wr] <= s1_resp;
  end

endmodule

// File: tb/tb_vc_sram_req_resp_adapter.sv
module tb_vc_sram_req_resp_adapter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_val = 1'b0, req_rdy, req_type = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_byte_en = '0;
  logic        resp_val, resp_rdy = 1'b1, resp_type;
  logic [31:0] resp_data;
  logic        sram_en, sram_write_en;
  logic [3:0]  sram_byte_en;
  logic [4:0]  sram_addr;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data = '0;

  vc_sram_req_resp_adapter #(.p_mem_sz(32), .p_data_sz(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_val(req_val), .req_rdy(req_rdy), .req_type(req_type),
    .req_addr(req_addr), .req_data(req_data), .req_byte_en(req_byte_en),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_type(resp_type),
    .resp_data(resp_data),
    .sram_en(sram_en), .sram_write_en(sram_write_en),
    .sram_byte_en(sram_byte_en), .sram_addr(sram_addr),
    .sram_write_data(sram_write_data), .sram_read_data(sram_read_data)
  );

  always #5 clk = ~clk;

  // Behavioural 1rw SRAM: one-cycle read latency, read-before-write, byte enables.
  logic [31:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    forever begin
      @(posedge clk);
      if (sram_en) begin
        sram_read_data <= mem[sram_addr];
        if (sram_write_en)
          for (int b = 0; b < 4; b++)
            if (sram_byte_en[b]) mem[sram_addr][8*b +: 8] <= sram_write_data[8*b +: 8];
      end
    end
  end

  // Reference model and scoreboard
  typedef struct {
    logic        typ;
    logic [31:0] data;
    int          cyc;
    bit          lat;
  } exp_t;

  logic [31:0] ref_mem [32];
  exp_t        exp_q [$];
  int          errors = 0, checks = 0;
  int          cyc = 0;
  bit          rnd_rdy = 1'b0;

  initial for (int i = 0; i < 32; i++) ref_mem[i] = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Called just after a posedge. Holds the request until it fires, then records
  // the expected response. When use_exp is set, the directed constant is the expectation.
  task automatic issue(input logic typ, input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit lat,
                       input bit use_exp = 1'b0, input logic [31:0] exp_d = '0);
    exp_t e;
    int   waits = 0;
    req_val = 1'b1; req_type = typ; req_addr = a; req_data = d; req_byte_en = be;
    forever begin
      @(negedge clk);
      if (req_rdy) break;
      waits++;
      if (waits > 60) begin
        chk("issue_timeout", 32'(waits), 32'd0);
        req_val = 1'b0;
        return;
      end
    end
    e.typ = typ; e.cyc = cyc; e.lat = lat;
    if (typ) begin
      e.data = '0;
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end else begin
      e.data = use_exp ? exp_d : ref_mem[a];
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_val = 1'b0;
  endtask

  // Monitor: credit, stall stability, ordering/content and latency checks
  initial begin
    int          n_fire = 0, n_resp = 0, outst;
    bit          stall = 1'b0;
    logic        p_typ;
    logic [31:0] p_data;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        n_fire = 0; n_resp = 0; stall = 1'b0;
      end else begin
        outst = n_fire - n_resp;
        chk("credit_req_rdy", 32'(req_rdy), 32'(outst < 2));
        if (outst > 2) chk("outstanding_le2", 32'(outst), 32'd2);
        if (stall) begin
          chk("stall_val",  32'(resp_val),  32'd1);
          chk("stall_type", 32'(resp_type), 32'(p_typ));
          chk("stall_data", resp_data, p_data);
        end
        if (resp_val && resp_rdy) begin
          if (exp_q.size() == 0) chk("spurious_resp", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("resp_type", 32'(resp_type), 32'(e.typ));
            chk("resp_data", resp_data, e.data);
            if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd1);
          end
        end
        stall  = resp_val && !resp_rdy;
        p_typ  = resp_type;
        p_data = resp_data;
        n_fire += int'(req_val && req_rdy);
        n_resp += int'(resp_val && resp_rdy);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_rdy) resp_rdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    // Reset state
    reset_n = 1'b0;
    #1;
    chk("rst_resp_val", 32'(resp_val), 32'd0);
    chk("rst_req_rdy",  32'(req_rdy),  32'd1);
    chk("rst_sram_en",  32'(sram_en),  32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Write then read, 1-cycle latency each
    issue(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b1);
    issue(1'b0, 5'd5, 32'h0, 4'h0, 1'b1, 1'b1, 32'hDEADBEEF);
    idle(2);

    // Partial write
    issue(1'b1, 5'd3, 32'h11223344, 4'hF, 1'b1);
    issue(1'b1, 5'd3, 32'hAABBCCDD, 4'b0101, 1'b1);
    issue(1'b0, 5'd3, 32'h0, 4'h0, 1'b1, 1'b1, 32'h11BB33DD);
    idle(2);

    // Streaming reads 0..7
    for (int i = 0; i < 8; i++) issue(1'b0, 5'(i), 32'h0, 4'h0, 1'b1);
    idle(2);

    // Backpressure: reads 1,2,3 with resp_rdy low
    for (int i = 1; i < 4; i++) issue(1'b1, 5'(i), 32'h100 * i + 32'h5A, 4'hF, 1'b1);
    idle(2);
    resp_rdy = 1'b0;
    issue(1'b0, 5'd1, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000015A);
    issue(1'b0, 5'd2, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000025A);
    fork
      issue(1'b0, 5'd3, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000035A);
      begin
        repeat (3) @(negedge clk);
        chk("bp_req_rdy_low", 32'(req_rdy), 32'd0);
        chk("bp_resp_val",    32'(resp_val), 32'd1);
        @(posedge clk); #1;
        resp_rdy = 1'b1;
      end
    join
    idle(3);

    // Random traffic with random resp_rdy
    rnd_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            4'($urandom_range(0, 15)), 1'b0);
    end
    rnd_rdy = 1'b0;
    #0 resp_rdy = 1'b1;
    idle(4);
    chk("random_drained", 32'(exp_q.size()), 32'd0);

    // Reset with 2 responses pending
    issue(1'b1, 5'd9, 32'hCAFEF00D, 4'hF, 1'b0);
    idle(2);
    resp_rdy = 1'b0;
    issue(1'b0, 5'd9, 32'h0, 4'h0, 1'b0);
    issue(1'b0, 5'd5, 32'h0, 4'h0, 1'b0);
    @(negedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_resp_val", 32'(resp_val), 32'd0);
    chk("midrst_req_rdy",  32'(req_rdy),  32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    resp_rdy = 1'b1;
    issue(1'b0, 5'd9, 32'h0, 4'h0, 1'b1, 1'b1, 32'hCAFEF00D);

    // Drain
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk); w++;
    end
    idle(2);
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
